ram_master: RTL and testbench
=============================

RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 Parameters SHALL be: ADDR_W, 8, address width; DATA_W, 8, data width; RAM_DEPTH, 31, number of valid RAM words (addresses 0..30).
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 Ports (name, direction, width, meaning):
- clock  in  1  sole clock; rising edge.
- resetn  in  1  synchronous active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when high together with req_valid at a rising edge.
- req_write  in  1  1 = single write, 0 = burst read.
- req_addr  in  ADDR_W  base address.
- req_len  in  2  beats minus 1 (reads: 1..4 beats); SHALL be 0 for writes.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response beat available.
- rsp_ready  in  1  response beat consumed when high together with rsp_valid at a rising edge.
- rsp_data  out  DATA_W  read data; 0 for write acknowledgements and errors.
- rsp_last  out  1  final beat of the transaction.
- rsp_err  out  1  transaction rejected.
- ram_wren  out  1  RAM write enable.
- ram_address  out  ADDR_W  RAM address.
- ram_data  out  DATA_W  RAM write data.
- ram_q  in  DATA_W  RAM read data; valid one cycle after ram_address is presented with ram_wren=0.

Function
REQ-004 States SHALL be IDLE, READ, WRITE, ERR and DRAIN. req_ready SHALL be 1 only in IDLE, and 0 while resetn is low.
REQ-005 On an accepted request, the block SHALL register req_write, req_addr, req_len and req_wdata, then transition as follows:
- to ERR if req_write=1 and req_len!=0;
- to ERR if the 9-bit sum req_addr+req_len > RAM_DEPTH-1;
- otherwise to WRITE or READ.
REQ-006 WRITE SHALL last exactly one cycle with ram_wren=1, ram_address=addr and ram_data=wdata. It SHALL then push one beat (data=0, last=1, err=0) and go to DRAIN.
REQ-007 READ SHALL issue at most one address per cycle, in the order base, base+1, ..., base+len, with ram_wren=0. An address SHALL issue only if (FIFO occupancy + in-flight reads) < 2.
REQ-008 ram_q SHALL be pushed into the response FIFO in the cycle after its address was issued. The push for beat base+len SHALL carry last=1; all pushes SHALL carry err=0.
REQ-009 After the final read address issues, the FSM SHALL go to DRAIN.
REQ-010 ERR SHALL last one cycle. It SHALL push one beat (data=0, last=1, err=1) with no RAM access: ram_wren=0 throughout.
REQ-011 DRAIN SHALL return to IDLE in the cycle after the last=1 beat is popped.
REQ-012 Minimum latency SHALL be:
- read: request accepted at edge E0 -> first address driven in cycle E0+1 -> rsp_valid=1 in cycle E0+3;
- write: ram_wren=1 in cycle E0+1 -> acknowledgement valid in cycle E0+2.
REQ-013 The response FIFO SHALL be 2 entries, each {data, last, err}, with no bypass. rsp_* outputs SHALL come directly from the head entry. A push and a pop in the same cycle SHALL both take effect.
REQ-014 With rsp_ready held low, no beat SHALL be lost or duplicated, and at most 2 read addresses SHALL be outstanding beyond the consumed beats.
REQ-015 ram_wren, ram_address and ram_data SHALL be registered. ram_address and ram_data SHALL hold their last value when not issuing. ram_wren SHALL be 1 only in WRITE.
REQ-016 Address arithmetic SHALL never wrap: the range check uses ADDR_W+1 bits.

Reset
REQ-017 While resetn is low at a rising edge, the block SHALL:
- enter IDLE;
- empty the FIFO and discard in-flight reads;
- drive rsp_valid=0, rsp_data=0, rsp_last=0, rsp_err=0, ram_wren=0, ram_address=0, ram_data=0, req_ready=0.
REQ-018 A reset arriving mid-burst or during WRITE SHALL abort the transaction with no further RAM access and no response beat. The first request SHALL be accepted at the first rising edge with resetn high.

Structure
REQ-019 Package ram_master_pkg SHALL hold the ADDR_W, DATA_W and RAM_DEPTH defaults, LEN_W=2, the state enum, and the response-entry struct {data, last, err}.
REQ-020 The response FIFO SHALL be the sub-module rsp_fifo (depth 2, with full and empty flags and a count output).

Verification
REQ-021 RAM preloaded with [0]=02, [1]=E7, [2]=03, [3]=10. Read addr 0, len 3, rsp_ready=1 -> beats 02, E7, 03, 10; rsp_last only on 10; first rsp_valid 3 cycles after acceptance.
REQ-022 Write addr 5, data 55 -> exactly one cycle with ram_wren=1, address 05, data 55; acknowledgement beat with data 0, last 1, err 0. Then read addr 5, len 0 -> 55.
REQ-023 Read addr 29, len 3 -> single beat with err=1, last=1, data=0; ram_wren never 1. Write with len=2 -> same error response.
REQ-024 Read addr 0, len 3 with rsp_ready=0 for 6 cycles then 1 -> exactly 2 addresses issued before stall; beats 02, E7, 03, 10 delivered in order with none lost.
REQ-025 resetn low for 1 cycle after the second beat of a 4-beat read -> rsp_valid=0 and ram_wren=0 after the edge; no further beats; a new read of addr 1, len 0 returns E7.

Source files
------------

// File: rtl/ram_master_pkg.sv
// Shared defaults and types for the RAM master: FSM state encoding and the
// response FIFO entry layout.
package ram_master_pkg;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_RAM_DEPTH = 31;
  localparam int LEN_W         = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    ERR   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  last;
    logic                  err;
  } rsp_entry_t;
endpackage

// File: rtl/ram_master_rsp_fifo.sv
// Two-entry response FIFO, no bypass: the head entry drives the response port.
// Push and pop in the same cycle both take effect; the caller gates push on full.
module rsp_fifo
  import ram_master_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       push,
  input  rsp_entry_t din,
  input  logic       pop,
  output rsp_entry_t head,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);
  rsp_entry_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_pop;

  assign do_pop = pop && !empty;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(do_pop);
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);
endmodule

// File: rtl/ram_master.sv
// Request/response front end for a synchronous single-port RAM: single writes,
// bursts of 1..4 reads, range-checked requests and a 2-deep response FIFO.
module ram_master
  import ram_master_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RAM_DEPTH = DEF_RAM_DEPTH
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_err,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  input  logic [DATA_W-1:0] ram_q
);
  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and req_ready is high only in IDLE.
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(RAM_DEPTH - 1);

  state_t              state, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W:0]      idx_q;
  logic                issued_q, issued_last_q;
  logic                pend_q, pend_last_q;
  logic                accept, range_err, len_err;
  logic [ADDR_W:0]     end_addr;
  logic                issue, issue_last;
  logic [ADDR_W-1:0]   issue_addr;
  logic                push_req, push, pop;
  rsp_entry_t          push_entry, head;
  logic                fifo_full, fifo_empty;
  logic [1:0]          fifo_count;
  logic [2:0]          occupancy;

  assign req_ready = resetn && (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign end_addr  = {1'b0, req_addr} + {{(ADDR_W+1-LEN_W){1'b0}}, req_len};
  assign range_err = end_addr > LAST_ADDR;
  assign len_err   = req_write && (req_len != '0);

  // Outstanding reads: address on the RAM bus (issued_q) plus data arriving (pend_q).
  assign occupancy = {1'b0, fifo_count} + 3'(issued_q) + 3'(pend_q);

  assign rsp_valid = !fifo_empty;
  assign rsp_data  = head.data;
  assign rsp_last  = head.last;
  assign rsp_err   = head.err;
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    state_d    = state;
    issue      = 1'b0;
    issue_last = 1'b0;
    issue_addr = addr_q + ADDR_W'(idx_q);
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (len_err || range_err) begin
            state_d = ERR;
          end else if (req_write) begin
            state_d = WRITE;
          end else begin
            // The base address goes out straight from the request edge.
            state_d    = READ;
            issue      = 1'b1;
            issue_addr = req_addr;
            issue_last = (req_len == '0);
          end
        end
      end
      READ: begin
        if (idx_q > {1'b0, len_q}) begin
          state_d = DRAIN;
        end else if (occupancy < 3'd2) begin
          issue      = 1'b1;
          issue_last = (idx_q == {1'b0, len_q});
          if (issue_last) state_d = DRAIN;
        end
      end
      WRITE:   state_d = DRAIN;
      ERR:     state_d = DRAIN;
      DRAIN:   if (pop && head.last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    push_entry = '0;
    push_req   = 1'b0;
    if (pend_q) begin
      push_req        = 1'b1;
      push_entry.data = ram_q;
      push_entry.last = pend_last_q;
    end else if (state == ERR) begin
      push_req        = 1'b1;
      push_entry.last = 1'b1;
      push_entry.err  = 1'b1;
    end else if (state == WRITE) begin
      push_req        = 1'b1;
      push_entry.last = 1'b1;
    end
  end

  assign push = push_req && (!fifo_full || pop);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state         <= IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      idx_q         <= '0;
      issued_q      <= 1'b0;
      issued_last_q <= 1'b0;
      pend_q        <= 1'b0;
      pend_last_q   <= 1'b0;
      ram_wren      <= 1'b0;
      ram_address   <= '0;
      ram_data      <= '0;
    end else begin
      state         <= state_d;
      issued_q      <= issue;
      issued_last_q <= issue_last;
      pend_q        <= issued_q;
      pend_last_q   <= issued_last_q;
      ram_wren      <= 1'b0;
      if (accept) begin
        addr_q <= req_addr;
        len_q  <= req_len;
        idx_q  <= (LEN_W+1)'(1);
      end else if (state == READ && issue) begin
        idx_q <= idx_q + 1'b1;
      end
      if (accept && state_d == WRITE) begin
        ram_wren    <= 1'b1;
        ram_address <= req_addr;
        ram_data    <= req_wdata;
      end else if (issue) begin
        ram_address <= issue_addr;
      end
    end
  end

  rsp_fifo u_rsp_fifo (
    .clock  (clock),
    .resetn (resetn),
    .push   (push),
    .din    (push_entry),
    .pop    (pop),
    .head   (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );
endmodule

// File: tb/tb_ram_master.sv
// Bench for ram_master: behavioural RAM, request driver, response scoreboard
// with an expected queue, and latency/RAM-bus observations.
module tb_ram_master;
  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [1:0] req_len = 2'd0;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       rsp_last;
  logic       rsp_err;
  logic       ram_wren;
  logic [7:0] ram_address;
  logic [7:0] ram_data;
  logic [7:0] ram_q = 8'h00;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int pops     = 0;
  int wren_cnt = 0;
  int wren_cyc = -1;
  int first_rsp_cyc = -1;
  logic [7:0] wren_addr = 8'h00;
  logic [7:0] wren_data = 8'h00;
  logic [9:0] exp_q[$];
  logic [7:0] mem [256];
  logic       mem_ready = 1'b0;

  always #5 clock = ~clock;

  ram_master dut (
    .clock       (clock),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_last    (rsp_last),
    .rsp_err     (rsp_err),
    .ram_wren    (ram_wren),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_q       (ram_q)
  );

  // Synchronous RAM: read data one cycle after the address.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'($urandom_range(0, 255));
      mem[0] <= 8'h02;
      mem[1] <= 8'hE7;
      mem[2] <= 8'h03;
      mem[3] <= 8'h10;
      mem_ready <= 1'b1;
    end else begin
      if (ram_wren) mem[ram_address] <= ram_data;
      ram_q <= mem[ram_address];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor and scoreboard
  always @(negedge clock) begin
    if (ram_wren) begin
      wren_cnt++;
      wren_addr = ram_address;
      wren_data = ram_data;
      wren_cyc  = cyc;
    end
    if (resetn && rsp_valid && first_rsp_cyc < 0) first_rsp_cyc = cyc;
    if (resetn && rsp_valid && rsp_ready) begin
      pops++;
      if (exp_q.size() == 0) chk("extra_beat", 32'(exp_q.size()), 32'd1);
      else chk("beat", {22'd0, rsp_data, rsp_last, rsp_err}, {22'd0, exp_q.pop_front()});
    end
  end

  task automatic push_exp(input logic w, input logic [7:0] a, input logic [1:0] l);
    logic [8:0] e;
    e = {1'b0, a} + 9'(l);
    if ((w && l != 2'd0) || e > 9'd30) exp_q.push_back({8'h00, 1'b1, 1'b1});
    else if (w) exp_q.push_back({8'h00, 1'b1, 1'b0});
    else for (int i = 0; i <= int'(l); i++)
      exp_q.push_back({mem[a + 8'(i)], (i == int'(l)), 1'b0});
  endtask

  // Drives one request; acc is the cycle number just before the accepting edge.
  task automatic send(input logic w, input logic [7:0] a, input logic [1:0] l,
                      input logic [7:0] d, output int acc);
    push_exp(w, a, l);
    first_rsp_cyc = -1;
    @(posedge clock); #1;
    req_valid = 1'b1; req_write = w; req_addr = a; req_len = l; req_wdata = d;
    acc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (req_ready) begin
        acc = cyc;
        break;
      end
    end
    chk("req_accepted", 32'(acc >= 0), 32'd1);
    @(posedge clock); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge clock); #1;
      if (rnd) rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (exp_q.size() == 0 && req_ready) done = 1'b1;
    end
    if (rnd) rsp_ready = 1'b1;
    chk("idle_reached", 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, w0, p0, p1, k;
    logic [7:0] ra;
    logic [1:0] rl;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_word", {22'd0, rsp_data, rsp_last, rsp_err}, 32'd0);
    chk("rst_ram_bus", {15'd0, ram_wren, ram_address, ram_data}, 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;

    // Four-beat read, latency
    send(1'b0, 8'd0, 2'd3, 8'h00, acc);
    wait_idle(1'b0);
    chk("rd_latency", 32'(first_rsp_cyc), 32'(acc + 3));

    // Single write then read-back
    w0 = wren_cnt;
    send(1'b1, 8'd5, 2'd0, 8'h55, acc);
    wait_idle(1'b0);
    chk("wr_wren_cycles", 32'(wren_cnt - w0), 32'd1);
    chk("wr_addr", 32'(wren_addr), 32'h05);
    chk("wr_data", 32'(wren_data), 32'h55);
    chk("wr_wren_cycle", 32'(wren_cyc), 32'(acc + 1));
    chk("wr_ack_latency", 32'(first_rsp_cyc), 32'(acc + 2));
    send(1'b0, 8'd5, 2'd0, 8'h00, acc);
    wait_idle(1'b0);

    // Rejected requests never touch the RAM
    w0 = wren_cnt;
    send(1'b0, 8'd29, 2'd3, 8'h00, acc);
    wait_idle(1'b0);
    chk("err_latency", 32'(first_rsp_cyc), 32'(acc + 2));
    send(1'b1, 8'd0, 2'd2, 8'h77, acc);
    wait_idle(1'b0);
    send(1'b0, 8'd255, 2'd0, 8'h00, acc);
    wait_idle(1'b0);
    send(1'b1, 8'd31, 2'd0, 8'h66, acc);
    wait_idle(1'b0);
    chk("err_no_wren", 32'(wren_cnt - w0), 32'd0);

    // Range boundary
    send(1'b0, 8'd30, 2'd0, 8'h00, acc);
    wait_idle(1'b0);
    send(1'b0, 8'd27, 2'd3, 8'h00, acc);
    wait_idle(1'b0);
    send(1'b0, 8'd28, 2'd3, 8'h00, acc);
    wait_idle(1'b0);

    // Back-pressure: only two reads may be outstanding
    rsp_ready = 1'b0;
    p0 = pops;
    send(1'b0, 8'd0, 2'd3, 8'h00, acc);
    repeat (5) @(negedge clock);
    chk("stall_last_addr", 32'(ram_address), 32'd1);
    chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("stall_no_pop", 32'(pops - p0), 32'd0);
    @(posedge clock); #1;
    rsp_ready = 1'b1;
    wait_idle(1'b0);

    // Reset in the middle of a burst
    p0 = pops;
    send(1'b0, 8'd0, 2'd3, 8'h00, acc);
    for (k = 0; k < 200; k++) begin
      @(posedge clock); #1;
      if (pops >= p0 + 2) break;
    end
    chk("two_beats_before_rst", 32'(pops - p0), 32'd2);
    resetn = 1'b0;
    exp_q.delete();
    @(negedge clock);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_ram_wren", 32'(ram_wren), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    p1 = pops;
    repeat (10) @(negedge clock);
    chk("no_beats_after_rst", 32'(pops - p1), 32'd0);
    send(1'b0, 8'd1, 2'd0, 8'h00, acc);
    wait_idle(1'b0);

    // Random reads/writes with random back-pressure
    for (int n = 0; n < 10; n++) begin
      ra = 8'($urandom_range(0, 31));
      rl = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) send(1'b1, ra, ($urandom_range(0, 1) == 0) ? 2'd0 : rl,
                                          8'($urandom_range(0, 255)), acc);
      else send(1'b0, ra, rl, 8'h00, acc);
      wait_idle(1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
